// File: rtl/tx_gearbox_pkg.sv
// Shared helpers for the TX gearbox FIFO: ratio and lane-width derivation and
// selection of one narrow beat out of a wide word.
package tx_gearbox_pkg;

  localparam int MAX_WORD_W = 1024;
  localparam int MAX_BEAT_W = 1024;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int calc_ratio(input int wr_w, input int rd_w);
    return wr_w / rd_w;
  endfunction

  // A ratio of 1 still needs a 1-bit lane counter so the signal exists.
  function automatic int lane_width(input int ratio);
    return (clog2(ratio) < 1) ? 1 : clog2(ratio);
  endfunction

  function automatic logic [MAX_BEAT_W-1:0] lane_select(
    input logic [MAX_WORD_W-1:0] word,
    input int                    lane,
    input int                    ratio,
    input int                    beat_w,
    input bit                    msb_first
  );
    int shift;
    shift = msb_first ? (ratio - 1 - lane) * beat_w : lane * beat_w;
    return MAX_BEAT_W'(word >> shift);
  endfunction

endpackage

// File: rtl/tx_gearbox_ram.sv
// Simple dual-port RAM with a registered read port; the array has no reset.
module tx_gearbox_ram #(
  parameter int DATA_W = 129,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/tx_gearbox_fifo.sv
// Width-down-converting FWFT FIFO: wide words in, narrow beats out, one beat per clock.
// Optional level counter enabled by defining TX_GEARBOX_FIFO_LEVEL_EN.
module tx_gearbox_fifo
  import tx_gearbox_pkg::*;
#(
  parameter int WR_DATA_WIDTH  = 128,
  parameter int RD_DATA_WIDTH  = 8,
  parameter int WR_DEPTH_WIDTH = 8,
  parameter int MSB_FIRST      = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [WR_DATA_WIDTH-1:0]  wr_data,
  input  logic                      wr_last,
  output logic                      wr_vld,
  input  logic                      rd_en,
  output logic                      rd_vld,
  output logic [RD_DATA_WIDTH-1:0]  rd_data,
  output logic                      rd_last,
  output logic [WR_DEPTH_WIDTH:0]   level
);

  localparam int RATIO = calc_ratio(WR_DATA_WIDTH, RD_DATA_WIDTH);
  localparam int LW    = lane_width(RATIO);
  localparam int PW    = WR_DEPTH_WIDTH + 1;
  localparam int SW    = WR_DATA_WIDTH + 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(RATIO - 1);

  // Handshakes: a word moves when wr_en && wr_vld, a beat moves when rd_en && rd_vld;
  // the valid side never waits on the enable and the enable is ignored while valid is low.
  logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic          wr_vld_q;
  logic          ram_wr, ram_rd, ram_empty, full_nxt;
  logic [SW-1:0] ram_q;
  logic          ram_q_vld;
  logic [SW-1:0] cur_word;
  logic          cur_vld;
  logic [LW-1:0] lane;
  logic          pop, release_word, load_cur;

  tx_gearbox_ram #(
    .DATA_W (SW),
    .ADDR_W (WR_DEPTH_WIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (ram_wr),
    .wr_addr (wr_ptr[WR_DEPTH_WIDTH-1:0]),
    .wr_data ({wr_last, wr_data}),
    .rd_en   (ram_rd),
    .rd_addr (rd_ptr[WR_DEPTH_WIDTH-1:0]),
    .rd_data (ram_q)
  );

  assign ram_empty    = (wr_ptr == rd_ptr);
  assign pop          = rd_en && cur_vld;
  assign release_word = pop && (lane == LAST_LANE);
  // The RAM output register refills the holding word in the same cycle the
  // last lane is popped, which is what keeps RATIO=1 bubble-free.
  assign load_cur     = ram_q_vld && (!cur_vld || release_word);
  assign ram_wr       = wr_en && wr_vld_q;
  assign ram_rd       = !ram_empty && (!ram_q_vld || load_cur);

  assign wr_ptr_nxt = wr_ptr + PW'(ram_wr);
  assign rd_ptr_nxt = rd_ptr + PW'(ram_rd);
  assign full_nxt   = (wr_ptr_nxt[PW-1] != rd_ptr_nxt[PW-1]) &&
                      (wr_ptr_nxt[PW-2:0] == rd_ptr_nxt[PW-2:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      wr_vld_q  <= 1'b0;
      ram_q_vld <= 1'b0;
      cur_vld   <= 1'b0;
      cur_word  <= '0;
      lane      <= '0;
    end else begin
      wr_ptr   <= wr_ptr_nxt;
      rd_ptr   <= rd_ptr_nxt;
      wr_vld_q <= !full_nxt;
      if (ram_rd)        ram_q_vld <= 1'b1;
      else if (load_cur) ram_q_vld <= 1'b0;
      if (load_cur) begin
        cur_word <= ram_q;
        cur_vld  <= 1'b1;
      end else if (release_word) begin
        cur_vld  <= 1'b0;
      end
      if (pop) lane <= release_word ? '0 : lane + 1'b1;
    end
  end

  assign wr_vld  = wr_vld_q;
  assign rd_vld  = cur_vld;
  assign rd_data = RD_DATA_WIDTH'(lane_select(MAX_WORD_W'(cur_word[WR_DATA_WIDTH-1:0]),
                                              int'(lane), RATIO, RD_DATA_WIDTH,
                                              MSB_FIRST != 0));
  assign rd_last = cur_vld && cur_word[WR_DATA_WIDTH] && (lane == LAST_LANE);

`ifdef TX_GEARBOX_FIFO_LEVEL_EN
  logic [PW-1:0] level_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= '0;
    end else if (ram_wr && !ram_rd) begin
      level_q <= level_q + 1'b1;
    end else if (ram_rd && !ram_wr) begin
      level_q <= level_q - 1'b1;
    end
  end

  assign level = level_q;
`else
  assign level = '0;
`endif

endmodule

// File: tb/tb_tx_gearbox_fifo.sv
// Directed bench for tx_gearbox_fifo: 128->8 MSB-first, 128->8 LSB-first and 32->32 instances.
module tb_tx_gearbox_fifo;

`ifdef TX_GEARBOX_FIFO_LEVEL_EN
  localparam bit LEVEL_EN = 1'b1;
`else
  localparam bit LEVEL_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- DUT signals ----------------
  logic         wr_en, wr_last, wr_vld, rd_en, rd_vld, rd_last;
  logic [127:0] wr_data;
  logic [7:0]   rd_data;
  logic [8:0]   level;

  logic         l_wr_en, l_wr_last, l_wr_vld, l_rd_en, l_rd_vld, l_rd_last;
  logic [127:0] l_wr_data;
  logic [7:0]   l_rd_data;
  logic [8:0]   l_level;

  logic         s_wr_en, s_wr_last, s_wr_vld, s_rd_en, s_rd_vld, s_rd_last;
  logic [31:0]  s_wr_data;
  logic [31:0]  s_rd_data;
  logic [4:0]   s_level;

  tx_gearbox_fifo #(
    .WR_DATA_WIDTH(128), .RD_DATA_WIDTH(8), .WR_DEPTH_WIDTH(8), .MSB_FIRST(1)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_last(wr_last),
    .wr_vld(wr_vld), .rd_en(rd_en), .rd_vld(rd_vld), .rd_data(rd_data),
    .rd_last(rd_last), .level(level)
  );

  tx_gearbox_fifo #(
    .WR_DATA_WIDTH(128), .RD_DATA_WIDTH(8), .WR_DEPTH_WIDTH(8), .MSB_FIRST(0)
  ) dut_lsb (
    .clk(clk), .rst(rst), .wr_en(l_wr_en), .wr_data(l_wr_data), .wr_last(l_wr_last),
    .wr_vld(l_wr_vld), .rd_en(l_rd_en), .rd_vld(l_rd_vld), .rd_data(l_rd_data),
    .rd_last(l_rd_last), .level(l_level)
  );

  tx_gearbox_fifo #(
    .WR_DATA_WIDTH(32), .RD_DATA_WIDTH(32), .WR_DEPTH_WIDTH(4), .MSB_FIRST(1)
  ) dut_r1 (
    .clk(clk), .rst(rst), .wr_en(s_wr_en), .wr_data(s_wr_data), .wr_last(s_wr_last),
    .wr_vld(s_wr_vld), .rd_en(s_rd_en), .rd_vld(s_rd_vld), .rd_data(s_rd_data),
    .rd_last(s_rd_last), .level(s_level)
  );

  // ---------------- scoreboard state ----------------
  int tests_run;
  int tests_failed;
  logic [7:0]  exp_q[$];
  logic [31:0] exp32_q[$];

  localparam logic [127:0] PATTERN = 128'h00112233445566778899AABBCCDDEEFF;

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] seq_word(input int base);
    logic [127:0] w;
    w = '0;
    for (int b = 0; b < 16; b++) w[127-8*b -: 8] = 8'(base + b);
    return w;
  endfunction

  function automatic logic [8:0] exp_level(input int words);
    return LEVEL_EN ? 9'(words) : 9'd0;
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    wr_en = 0; wr_last = 0; wr_data = '0; rd_en = 0;
    l_wr_en = 0; l_wr_last = 0; l_wr_data = '0; l_rd_en = 0;
    s_wr_en = 0; s_wr_last = 0; s_wr_data = '0; s_rd_en = 0;
    tick(); tick();
    tests_run++;
    if (wr_vld !== 1'b0) begin tests_failed++; $display("FAIL reset_wr_vld: got %b want 0", wr_vld); end
    tests_run++;
    if (rd_vld !== 1'b0) begin tests_failed++; $display("FAIL reset_rd_vld: got %b want 0", rd_vld); end
    tests_run++;
    if (rd_data !== 8'h00) begin tests_failed++; $display("FAIL reset_rd_data: got %h want 00", rd_data); end
    tests_run++;
    if (rd_last !== 1'b0) begin tests_failed++; $display("FAIL reset_rd_last: got %b want 0", rd_last); end
    tests_run++;
    if (level !== 9'd0) begin tests_failed++; $display("FAIL reset_level: got %0d want 0", level); end
    tests_run++;
    if (s_rd_vld !== 1'b0) begin tests_failed++; $display("FAIL reset_r1_rd_vld: got %b want 0", s_rd_vld); end
    rst = 1'b0;
    tick();
    tests_run++;
    if (wr_vld !== 1'b1) begin tests_failed++; $display("FAIL post_reset_wr_vld: got %b want 1", wr_vld); end
    tests_run++;
    if (l_wr_vld !== 1'b1) begin tests_failed++; $display("FAIL post_reset_lsb_wr_vld: got %b want 1", l_wr_vld); end
  endtask

  task automatic test_msb_first();
    wr_data = PATTERN; wr_en = 1; rd_en = 1;
    tick();
    wr_en = 0;
    tests_run++;
    if (rd_vld !== 1'b0) begin tests_failed++; $display("FAIL msb_latency_k0: got %b want 0", rd_vld); end
    tick();
    tests_run++;
    if (rd_vld !== 1'b0) begin tests_failed++; $display("FAIL msb_latency_k1: got %b want 0", rd_vld); end
    tick();
    for (int i = 0; i < 16; i++) begin
      tests_run++;
      if (rd_vld !== 1'b1 || rd_data !== 8'(i * 17) || rd_last !== 1'b0) begin
        tests_failed++;
        $display("FAIL msb_beat%0d: got vld=%b data=%h last=%b want vld=1 data=%h last=0",
                 i, rd_vld, rd_data, rd_last, 8'(i * 17));
      end
      tick();
    end
    tests_run++;
    if (rd_vld !== 1'b0) begin tests_failed++; $display("FAIL msb_after_word: rd_vld got %b want 0", rd_vld); end
    rd_en = 0;
  endtask

  task automatic test_lsb_first();
    l_wr_data = PATTERN; l_wr_en = 1; l_rd_en = 1;
    tick();
    l_wr_en = 0;
    tick(); tick();
    for (int i = 0; i < 16; i++) begin
      tests_run++;
      if (l_rd_vld !== 1'b1 || l_rd_data !== 8'(255 - i * 17)) begin
        tests_failed++;
        $display("FAIL lsb_beat%0d: got vld=%b data=%h want vld=1 data=%h",
                 i, l_rd_vld, l_rd_data, 8'(255 - i * 17));
      end
      tick();
    end
    tests_run++;
    if (l_rd_vld !== 1'b0) begin tests_failed++; $display("FAIL lsb_after_word: rd_vld got %b want 0", l_rd_vld); end
    l_rd_en = 0;
  endtask

  task automatic test_fill_drain();
    int accepted;
    int beats;
    logic [7:0] exp;
    exp_q.delete();
    rd_en = 0;
    accepted = 0;
    for (int c = 0; c < 300 && wr_vld; c++) begin
      wr_data = seq_word(accepted * 16); wr_last = 0; wr_en = 1;
      tick();
      for (int b = 0; b < 16; b++) exp_q.push_back(8'(accepted * 16 + b));
      accepted++;
    end
    wr_data = seq_word(8'h5A);
    tick();
    wr_en = 0;
    tests_run++;
    if (accepted != 258) begin tests_failed++; $display("FAIL fill_accepted: got %0d want 258", accepted); end
    tests_run++;
    if (wr_vld !== 1'b0) begin tests_failed++; $display("FAIL fill_wr_vld: got %b want 0", wr_vld); end
    tests_run++;
    if (level !== exp_level(256)) begin tests_failed++; $display("FAIL fill_level: got %0d want %0d", level, exp_level(256)); end
    tick();
    tests_run++;
    if (rd_vld !== 1'b1 || rd_data !== 8'h00) begin
      tests_failed++; $display("FAIL fill_hold: got vld=%b data=%h want vld=1 data=00", rd_vld, rd_data);
    end
    rd_en = 1;
    beats = 0;
    for (int c = 0; c < 5000 && exp_q.size() > 0; c++) begin
      if (rd_vld) begin
        exp = exp_q.pop_front();
        tests_run++;
        if (rd_data !== exp) begin
          tests_failed++; $display("FAIL drain_beat%0d: got %h want %h", beats, rd_data, exp);
        end
        beats++;
      end
      tick();
    end
    tests_run++;
    if (beats != 4128) begin tests_failed++; $display("FAIL drain_count: got %0d want 4128", beats); end
    tick(); tick();
    tests_run++;
    if (rd_vld !== 1'b0) begin tests_failed++; $display("FAIL drain_empty: rd_vld got %b want 0", rd_vld); end
    tests_run++;
    if (level !== exp_level(0)) begin tests_failed++; $display("FAIL drain_level: got %0d want %0d", level, exp_level(0)); end
    tests_run++;
    if (wr_vld !== 1'b1) begin tests_failed++; $display("FAIL drain_wr_vld: got %b want 1", wr_vld); end
    rd_en = 0;
  endtask

  task automatic test_stream_last();
    int n;
    int gaps;
    logic [7:0] exp;
    exp_q.delete();
    rd_en = 1;
    n = 0; gaps = 0;
    for (int t = 0; t < 8 * 16 + 40; t++) begin
      if (rd_vld) begin
        exp = exp_q.pop_front();
        tests_run++;
        if (rd_data !== exp || rd_last !== (n == 63)) begin
          tests_failed++;
          $display("FAIL stream_beat%0d: got data=%h last=%b want data=%h last=%b",
                   n, rd_data, rd_last, exp, (n == 63));
        end
        n++;
      end else if (n > 0 && n < 128) begin
        gaps++;
      end
      if (t % 16 == 0 && t < 128) begin
        wr_en = 1; wr_data = seq_word(t + 32); wr_last = (t == 48);
        for (int b = 0; b < 16; b++) exp_q.push_back(8'(t + 32 + b));
      end else begin
        wr_en = 0; wr_last = 0;
      end
      tick();
    end
    wr_en = 0; rd_en = 0;
    tests_run++;
    if (n != 128) begin tests_failed++; $display("FAIL stream_count: got %0d want 128", n); end
    tests_run++;
    if (gaps != 0) begin tests_failed++; $display("FAIL stream_gaps: got %0d want 0", gaps); end
  endtask

  task automatic test_ratio1();
    int n;
    int w;
    int gaps;
    logic [31:0] exp;
    exp32_q.delete();
    s_rd_en = 1;
    n = 0; w = 0; gaps = 0;
    for (int t = 0; t < 80; t++) begin
      if (s_rd_vld) begin
        exp = exp32_q.pop_front();
        tests_run++;
        if (s_rd_data !== exp || s_rd_last !== (n == 39)) begin
          tests_failed++;
          $display("FAIL r1_beat%0d: got data=%h last=%b want data=%h last=%b",
                   n, s_rd_data, s_rd_last, exp, (n == 39));
        end
        n++;
      end else if (n > 0 && n < 40) begin
        gaps++;
      end
      if (w < 40 && s_wr_vld) begin
        s_wr_en = 1; s_wr_data = 32'hC0DE0000 + 32'(w); s_wr_last = (w == 39);
        exp32_q.push_back(32'hC0DE0000 + 32'(w));
        w++;
      end else begin
        s_wr_en = 0; s_wr_last = 0;
      end
      tick();
    end
    s_wr_en = 0; s_rd_en = 0;
    tests_run++;
    if (n != 40) begin tests_failed++; $display("FAIL r1_count: got %0d want 40", n); end
    tests_run++;
    if (gaps != 0) begin tests_failed++; $display("FAIL r1_gaps: got %0d want 0", gaps); end
    tests_run++;
    if (s_rd_vld !== 1'b0) begin tests_failed++; $display("FAIL r1_empty: rd_vld got %b want 0", s_rd_vld); end
  endtask

  task automatic test_reset_mid();
    rd_en = 0;
    wr_en = 1; wr_last = 0; wr_data = PATTERN;
    tick();
    wr_data = seq_word(8'h80);
    tick();
    wr_en = 0;
    for (int c = 0; c < 10 && !rd_vld; c++) tick();
    rd_en = 1;
    for (int i = 0; i < 5; i++) tick();
    tests_run++;
    if (rd_vld !== 1'b1 || rd_data !== 8'h55) begin
      tests_failed++; $display("FAIL mid_pre_reset: got vld=%b data=%h want vld=1 data=55", rd_vld, rd_data);
    end
    rst = 1; rd_en = 0;
    tick();
    tests_run++;
    if (rd_vld !== 1'b0) begin tests_failed++; $display("FAIL mid_rd_vld: got %b want 0", rd_vld); end
    tests_run++;
    if (rd_data !== 8'h00) begin tests_failed++; $display("FAIL mid_rd_data: got %h want 00", rd_data); end
    tests_run++;
    if (level !== 9'd0) begin tests_failed++; $display("FAIL mid_level: got %0d want 0", level); end
    tests_run++;
    if (wr_vld !== 1'b0) begin tests_failed++; $display("FAIL mid_wr_vld: got %b want 0", wr_vld); end
    rst = 0;
    tick();
    tests_run++;
    if (wr_vld !== 1'b1) begin tests_failed++; $display("FAIL mid_wr_vld_back: got %b want 1", wr_vld); end
    wr_en = 1; wr_data = seq_word(8'hA0); rd_en = 1;
    tick();
    wr_en = 0;
    for (int c = 0; c < 10 && !rd_vld; c++) tick();
    tests_run++;
    if (rd_vld !== 1'b1) begin tests_failed++; $display("FAIL mid_refill_timeout: rd_vld got %b want 1", rd_vld); end
    for (int i = 0; i < 16; i++) begin
      tests_run++;
      if (rd_vld !== 1'b1 || rd_data !== 8'(8'hA0 + i)) begin
        tests_failed++;
        $display("FAIL mid_beat%0d: got vld=%b data=%h want vld=1 data=%h", i, rd_vld, rd_data, 8'(8'hA0 + i));
      end
      tick();
    end
    tick();
    tests_run++;
    if (rd_vld !== 1'b0) begin tests_failed++; $display("FAIL mid_no_stale: rd_vld got %b want 0", rd_vld); end
    rd_en = 0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_fill_drain();
    test_stream_last();
    test_ratio1();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
